draw_sequencer: RTL

- Parametrised scheduler that grants a pixel-write port to NUM_SRC drawing engines in turn.
- Each engine is granted a programmable number of pixel beats; the output handshakes with the frame-buffer writer, and the schedule can run once or repeat every frame.
- Sits between the drawing engines (clear, waveform, etc.) and the frame-buffer write port.
- Replaces a hard-coded two-engine, fixed-split selector with a handshaked, width-generic, N-source sequencer.

---
 rtl/draw_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/draw_sequencer.sv
// Round-robin pixel-write scheduler: grants the frame-buffer write port to
// NUM_SRC drawing engines in turn, each for a programmable number of beats.
module draw_sequencer #(
   parameter int NUM_SRC = 2,
   parameter int X_W     = 8,
   parameter int Y_W     = 8,
   parameter int COLOR_W = 12,
   parameter int CNT_W   = 16,
   parameter int LOOP    = 0,
   localparam int AW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       start_i,
   input  logic                       stop_i,
   input  logic [NUM_SRC*CNT_W-1:0]   phase_len_i,
   input  logic [NUM_SRC-1:0]         src_valid_i,
   input  logic [NUM_SRC*X_W-1:0]     src_x_i,
   input  logic [NUM_SRC*Y_W-1:0]     src_y_i,
   input  logic [NUM_SRC*COLOR_W-1:0] src_color_i,
   output logic [NUM_SRC-1:0]         src_ready_o,
   output logic                       wr_valid_o,
   output logic [X_W-1:0]             wr_x_o,
   output logic [Y_W-1:0]             wr_y_o,
   output logic [COLOR_W-1:0]         wr_color_o,
   input  logic                       wr_ready_i,
   output logic [AW-1:0]              active_src_o,
   output logic                       busy_o,
   output logic                       done_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e                     state_q, state_d;
   logic [NUM_SRC*CNT_W-1:0]   len_q, len_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [AW-1:0]              act_q, act_d;
   logic                       stop_q, stop_d;
   logic                       wv_q, wv_d;
   logic [X_W-1:0]             wx_q, wx_d;
   logic [Y_W-1:0]             wy_q, wy_d;
   logic [COLOR_W-1:0]         wc_q, wc_d;
   logic                       done_q, done_d;

   logic [CNT_W-1:0] cur_len;
   logic             out_free;
   logic             last_src;
   logic             phase_end;

   assign cur_len  = len_q[int'(act_q)*CNT_W +: CNT_W];
   assign out_free = !wv_q || wr_ready_i;
   assign last_src = (int'(act_q) == NUM_SRC - 1);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      act_d       = act_q;
      stop_d      = stop_q | ((state_q != S_IDLE) && stop_i);
      wv_d        = wv_q && !wr_ready_i;
      wx_d        = wx_q;
      wy_d        = wy_q;
      wc_d        = wc_q;
      done_d      = 1'b0;
      phase_end   = 1'b0;
      src_ready_o = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               len_d   = phase_len_i;
               cnt_d   = '0;
               act_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // a zero-length phase burns one cycle with no grant
            if (cur_len == '0) begin
               phase_end = 1'b1;
            end else begin
               src_ready_o[act_q] = out_free;
               if (src_valid_i[act_q] && out_free) begin
                  wv_d = 1'b1;
                  wx_d = src_x_i[int'(act_q)*X_W +: X_W];
                  wy_d = src_y_i[int'(act_q)*Y_W +: Y_W];
                  wc_d = src_color_i[int'(act_q)*COLOR_W +: COLOR_W];
                  if (cnt_q == cur_len - CNT_W'(1)) phase_end = 1'b1;
                  else cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (phase_end) begin
               cnt_d = '0;
               if (last_src) state_d = S_DRAIN;
               else act_d = act_q + AW'(1);
            end
         end
         S_DRAIN: begin
            if (out_free) begin
               done_d = 1'b1;
               if (LOOP == 0 || stop_q || stop_i) begin
                  state_d = S_IDLE;
                  stop_d  = 1'b0;
               end else begin
                  state_d = S_RUN;
                  act_d   = '0;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         cnt_q   <= '0;
         act_q   <= '0;
         stop_q  <= 1'b0;
         wv_q    <= 1'b0;
         wx_q    <= '0;
         wy_q    <= '0;
         wc_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         stop_q  <= stop_d;
         wv_q    <= wv_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
         wc_q    <= wc_d;
         done_q  <= done_d;
      end
   end

   assign wr_valid_o   = wv_q;
   assign wr_x_o       = wx_q;
   assign wr_y_o       = wy_q;
   assign wr_color_o   = wc_q;
   assign active_src_o = act_q;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = done_q;

endmodule
